inst_parse_q: RTL and testbench
===============================

Name: inst_parse_q

Overview:
- Next-generation instruction parser node for the daisy-chained instruction bus.
- Decodes each incoming instruction word and consumes words addressed to this node's ID:
  - writes the payload into one of IN local instruction registers;
  - queues start requests, with priority, into a small start FIFO.
- Forwards all other words downstream through a full-throughput 2-entry skid buffer.
- Generalises field widths and start-queue depth, qualifies register writes by handshake, and flags out-of-range addresses.

Parameters:
- IW, 32, total instruction word width.
- IDW, 3, node ID field width.
- AW, 4, local register address field width.
- PW, 2, priority field width.
- DW, 16, payload (data) field width; local register width.
- IN, 6, number of local instruction registers; requires IN <= 2**AW.
- SD, 4, start FIFO depth; power of two, >= 2.
- ID, 0, this node's ID; IDW bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_m_data  in  IW  upstream instruction word.
- inst_m_valid  in  1  upstream valid.
- inst_m_ready  out  1  upstream ready.
- inst_s_data  out  IW  downstream instruction word.
- inst_s_valid  out  1  downstream valid.
- inst_s_ready  in  1  downstream ready.
- local_inst  out  IN*DW  local registers; register i is at [DW*i +: DW].
- start_prior  out  PW  priority of the start request at the FIFO head.
- start_valid  out  1  start FIFO not empty.
- start_ready  in  1  pops the FIFO head.
- start_cnt  out  log2(SD)+1  start FIFO occupancy.
- addr_err  out  1  sticky: a local write targeted an address >= IN.
- err_clr  in  1  synchronous clear of addr_err.

Behaviour:
- Field layout, MSB to LSB: run[1], id[IDW], addr[AW], prior[PW], rfu[IW-1-IDW-AW-PW-DW], data[DW]. rfu is ignored.
- A word is local when id == ID; otherwise it is a forward word.
- Reset values:
  - all local registers, start_prior, start_cnt, addr_err: 0;
  - start_valid, inst_s_valid: 0;
  - inst_s_data: 0;
  - skid buffer and FIFO pointers: empty.
- Local word readiness:
  - run=0: always ready;
  - run=1: ready when start_cnt < SD, or when a pop happens in the same cycle (start_valid && start_ready).
- Forward word readiness: skid buffer is not full.
- inst_m_ready is combinational from id, run and the readiness conditions above.
- Accept means inst_m_valid && inst_m_ready. On accepting a local word:
  - addr < IN: reg[addr] <= data on the next clock edge;
  - addr >= IN: no register write; addr_err <= 1;
  - run=1: push prior into the start FIFO, in the same cycle as any register write.
- No write and no push happen without a handshake. Holding valid low with arbitrary data changes nothing.
- The start FIFO is in-order, not priority-sorted.
  - start_valid and start_prior come from registered FIFO state (head entry).
  - Pop on start_valid && start_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - A push into a full FIFO is impossible by construction.
  - Pointers wrap modulo SD.
- Skid buffer:
  - 2 entries; inst_s_valid/inst_s_data are registered; latency 1 cycle from accept to downstream valid;
  - sustains 1 word/cycle when inst_s_ready is held high;
  - preserves order; never drops or duplicates a word under backpressure;
  - data is stable while inst_s_valid && !inst_s_ready.
- addr_err:
  - err_clr clears it;
  - if err_clr and a new error occur in the same cycle, the set wins.
- Reset asserted mid-operation flushes the FIFO and the skid buffer immediately; in-flight words are lost.

Optional Feature:
- Macro: INST_PARSE_BCAST_EN.
- Defined: id == all-ones is a broadcast word.
  - It is consumed locally (register write, and start push if run=1) and also forwarded.
  - inst_m_ready for a broadcast word = local readiness AND skid not full.
  - The ID parameter must not equal all-ones.
- Undefined: all-ones is an ordinary ID; there is no broadcast logic.

Test Plan:
- Reset, then a local write: id=0, run=0, addr=2, data=0xBEEF -> local_inst[47:32]=0xBEEF one cycle later; no start push; inst_s_valid stays 0.
- With start_ready=0, send 5 local words with run=1 and prior 0,1,2,3,0 -> the first 4 are accepted; inst_m_ready=0 on the 5th; start_cnt=4. Assert start_ready -> pops return priors 0,1,2,3, then the 5th is accepted.
- Stream 8 forward words with id=3 while inst_s_ready toggles 1,0,1,0 -> all 8 appear downstream in order, with no loss and no duplicates; data is held stable while stalled.
- Local write to addr=7 with IN=6 -> no register changes; addr_err=1. Pulse err_clr -> addr_err=0.
- inst_m_valid=0 with local data addr=1 on the bus -> no register write (handshake qualification).
- Broadcast (macro defined): id=7, addr=0, data=0x1234, run=1 -> reg0=0x1234, one start push, and the word also forwarded downstream.

Source files
------------

// File: rtl/inst_parse_q.sv
// Instruction parser node: consumes words addressed to ID (local register write, start queue push)
// and forwards the rest through a 2-entry skid buffer. Optional broadcast: INST_PARSE_BCAST_EN.
module inst_parse_q #(
   parameter int IW  = 32,
   parameter int IDW = 3,
   parameter int AW  = 4,
   parameter int PW  = 2,
   parameter int DW  = 16,
   parameter int IN  = 6,
   parameter int SD  = 4,
   parameter int ID  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IW-1:0]        inst_m_data,
   input  logic                 inst_m_valid,
   output logic                 inst_m_ready,
   output logic [IW-1:0]        inst_s_data,
   output logic                 inst_s_valid,
   input  logic                 inst_s_ready,
   output logic [IN*DW-1:0]     local_inst,
   output logic [PW-1:0]        start_prior,
   output logic                 start_valid,
   input  logic                 start_ready,
   output logic [$clog2(SD):0]  start_cnt,
   output logic                 addr_err,
   input  logic                 err_clr
);

   localparam int ID_LSB = IW - 1 - IDW;
   localparam int AD_LSB = ID_LSB - AW;
   localparam int PR_LSB = AD_LSB - PW;
   localparam int PTRW   = $clog2(SD);
   localparam int CW     = PTRW + 1;

   logic            w_run;
   logic [IDW-1:0]  w_id;
   logic [AW-1:0]   w_addr;
   logic [PW-1:0]   w_prior;
   logic [DW-1:0]   w_data;
   logic            unused_rfu;

   assign w_run      = inst_m_data[IW-1];
   assign w_id       = inst_m_data[ID_LSB +: IDW];
   assign w_addr     = inst_m_data[AD_LSB +: AW];
   assign w_prior    = inst_m_data[PR_LSB +: PW];
   assign w_data     = inst_m_data[DW-1:0];
   assign unused_rfu = ^inst_m_data[PR_LSB-1:DW];

   logic is_local, is_bcast, addr_ok, local_rdy, skid_full;
   logic acc, local_acc, fwd_acc, push, pop;
   logic skid_valid;
   logic [IW-1:0] skid_data;

   assign is_local = (w_id == IDW'(ID));
`ifdef INST_PARSE_BCAST_EN
   assign is_bcast = &w_id;
`else
   assign is_bcast = 1'b0;
`endif

   assign addr_ok   = ({1'b0, w_addr} < (AW+1)'(IN));
   assign pop       = start_valid && start_ready;
   assign local_rdy = !w_run || (start_cnt < CW'(SD)) || pop;
   assign skid_full = skid_valid;

   // All ports use valid/ready: a transfer happens on a clock edge where both are high;
   // a producer holds valid and data stable until that edge, and ready may depend on data.
   always_comb begin
      inst_m_ready = 1'b0;
      if (is_bcast)
         inst_m_ready = local_rdy && !skid_full;
      else if (is_local)
         inst_m_ready = local_rdy;
      else
         inst_m_ready = !skid_full;
   end

   // ID never equals all-ones when broadcast is enabled, so !is_local covers broadcast words.
   assign acc       = inst_m_valid && inst_m_ready;
   assign local_acc = acc && (is_local || is_bcast);
   assign fwd_acc   = acc && !is_local;
   assign push      = local_acc && w_run;

   logic [DW-1:0] regs [IN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IN; i++) regs[i] <= '0;
      end else if (local_acc && addr_ok) begin
         for (int i = 0; i < IN; i++)
            if (w_addr == AW'(i)) regs[i] <= w_data;
      end
   end

   for (genvar g = 0; g < IN; g++) begin : g_out
      assign local_inst[DW*g +: DW] = regs[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr_err <= 1'b0;
      else if (local_acc && !addr_ok)
         addr_err <= 1'b1;
      else if (err_clr)
         addr_err <= 1'b0;
   end

   logic [PW-1:0]   fifo_mem [SD];
   logic [PTRW-1:0] wr_ptr, rd_ptr;

   // In-order start queue; a push while full only happens together with a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SD; i++) fifo_mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         start_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= w_prior;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         start_cnt <= start_cnt + CW'(push) - CW'(pop);
      end
   end

   assign start_valid = (start_cnt != '0);
   assign start_prior = fifo_mem[rd_ptr];

   // Output register plus one skid register; the skid slot is only filled while the output stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_s_valid <= 1'b0;
         inst_s_data  <= '0;
         skid_valid   <= 1'b0;
         skid_data    <= '0;
      end else if (!inst_s_valid || inst_s_ready) begin
         if (skid_valid) begin
            inst_s_data  <= skid_data;
            inst_s_valid <= 1'b1;
            skid_valid   <= 1'b0;
         end else if (fwd_acc) begin
            inst_s_data  <= inst_m_data;
            inst_s_valid <= 1'b1;
         end else begin
            inst_s_valid <= 1'b0;
         end
      end else if (fwd_acc) begin
         skid_data  <= inst_m_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_parse_q.sv
// Bench for inst_parse_q: directed scenarios plus random traffic, checked against a queue-based model.
module tb_inst_parse_q;

   localparam int IW = 32, IDW = 3, AW = 4, PW = 2, DW = 16, IN = 6, SD = 4, ID = 0;
   localparam int CW = $clog2(SD) + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [IW-1:0]      inst_m_data;
   logic               inst_m_valid;
   logic               inst_m_ready;
   logic [IW-1:0]      inst_s_data;
   logic               inst_s_valid;
   logic               inst_s_ready;
   logic [IN*DW-1:0]   local_inst;
   logic [PW-1:0]      start_prior;
   logic               start_valid;
   logic               start_ready;
   logic [CW-1:0]      start_cnt;
   logic               addr_err;
   logic               err_clr;

   // clock / reset
   always #5 clk = ~clk;

   inst_parse_q #(.IW(IW), .IDW(IDW), .AW(AW), .PW(PW), .DW(DW), .IN(IN), .SD(SD), .ID(ID)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_m_data(inst_m_data), .inst_m_valid(inst_m_valid), .inst_m_ready(inst_m_ready),
      .inst_s_data(inst_s_data), .inst_s_valid(inst_s_valid), .inst_s_ready(inst_s_ready),
      .local_inst(local_inst), .start_prior(start_prior), .start_valid(start_valid),
      .start_ready(start_ready), .start_cnt(start_cnt), .addr_err(addr_err), .err_clr(err_clr)
   );

   // scoreboard / reference model
   int              n_pass = 0;
   int              n_chk  = 0;
   int              n_out  = 0;
   logic [IW-1:0]   exp_q[$];
   logic [PW-1:0]   start_q[$];
   logic [DW-1:0]   reg_m [IN];
   logic            err_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [IW-1:0] mk(input bit run, input int id, input int addr,
                                        input int prior, input int data);
      logic [IW-1:0] w;
      w = '0;
      w[IW-1]            = run;
      w[IW-2 -: IDW]     = IDW'(id);
      w[IW-2-IDW -: AW]  = AW'(addr);
      w[IW-2-IDW-AW -: PW] = PW'(prior);
      w[DW-1:0]          = DW'(data);
      return w;
   endfunction

   function automatic bit is_bc(input logic [IW-1:0] w);
      bit bc;
      bc = 1'b0;
`ifdef INST_PARSE_BCAST_EN
      bc = (int'(w[IW-2 -: IDW]) == (2**IDW) - 1);
`endif
      return bc;
   endfunction

   function automatic bit model_ready(input logic [IW-1:0] w, input bit srdy);
      bit loc_ok, fwd_ok;
      loc_ok = !w[IW-1] || (start_q.size() < SD) || (start_q.size() > 0 && srdy);
      fwd_ok = exp_q.size() < 2;
      if (is_bc(w)) return loc_ok && fwd_ok;
      if (int'(w[IW-2 -: IDW]) == ID) return loc_ok;
      return fwd_ok;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      start_q.delete();
      for (int i = 0; i < IN; i++) reg_m[i] = '0;
      err_m = 1'b0;
   endtask

   task automatic check_state();
      check("s_valid", inst_s_valid, exp_q.size() > 0);
      check("start_valid", start_valid, start_q.size() > 0);
      check("start_cnt", start_cnt, start_q.size());
      if (start_q.size() > 0) check("start_prior", start_prior, start_q[0]);
      check("addr_err", addr_err, err_m);
      for (int i = 0; i < IN; i++)
         check($sformatf("reg%0d", i), local_inst[DW*i +: DW], reg_m[i]);
   endtask

   // driver: one clock cycle of stimulus, model update and output check
   task automatic step(input bit v, input logic [IW-1:0] w, input bit srdy,
                       input bit dsrdy, input bit clr);
      bit rdy, acc, loc, fwd;
      int addr;
      inst_m_valid = v;
      inst_m_data  = w;
      start_ready  = srdy;
      inst_s_ready = dsrdy;
      err_clr      = clr;
      #1;
      rdy  = model_ready(w, srdy);
      check("m_ready", inst_m_ready, rdy);
      if (exp_q.size() > 0) check("s_data", inst_s_data, exp_q[0]);
      if (inst_s_valid && inst_s_ready) n_out++;
      acc  = v && rdy;
      loc  = is_bc(w) || (int'(w[IW-2 -: IDW]) == ID);
      fwd  = is_bc(w) || (int'(w[IW-2 -: IDW]) != ID);
      addr = int'(w[IW-2-IDW -: AW]);
      @(posedge clk);
      if (exp_q.size() > 0 && dsrdy) exp_q.delete(0);
      if (start_q.size() > 0 && srdy) start_q.delete(0);
      if (acc && fwd) exp_q.push_back(w);
      if (acc && loc) begin
         if (addr < IN) reg_m[addr] = w[DW-1:0];
         if (w[IW-1]) start_q.push_back(w[IW-2-IDW-AW -: PW]);
      end
      if (acc && loc && addr >= IN) err_m = 1'b1;
      else if (clr) err_m = 1'b0;
      #1;
      check_state();
   endtask

   task automatic idle(input int n, input bit srdy, input bit dsrdy);
      for (int i = 0; i < n; i++) step(1'b0, '0, srdy, dsrdy, 1'b0);
   endtask

   initial begin
      logic [IW-1:0] w;
      int            tries;
      int            out0;
      int            ids [4];
      ids = '{0, 3, 5, 7};

      rst_n = 1'b0;
      inst_m_valid = 1'b0; inst_m_data = '0; start_ready = 1'b0;
      inst_s_ready = 1'b0; err_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_s_data", inst_s_data, 0);
      check_state();

      // local write, no push, nothing forwarded
      step(1'b1, mk(0, 0, 2, 0, 'hBEEF), 1'b0, 1'b1, 1'b0);
      check("reg2_beef", local_inst[47:32], 'hBEEF);
      check("no_fwd", inst_s_valid, 0);

      // start FIFO fills, fifth push waits until a pop frees room
      for (int i = 0; i < 4; i++) step(1'b1, mk(1, 0, 0, i, i), 1'b0, 1'b1, 1'b0);
      check("cnt_full", start_cnt, 4);
      step(1'b1, mk(1, 0, 1, 0, 'h55), 1'b0, 1'b1, 1'b0);
      check("full_blocks", inst_m_ready, 0);
      check("head_prior0", start_prior, 0);
      step(1'b1, mk(1, 0, 1, 0, 'h55), 1'b1, 1'b1, 1'b0);
      check("cnt_push_pop", start_cnt, 4);
      idle(6, 1'b1, 1'b1);

      // forward stream under toggling backpressure
      out0 = n_out;
      for (int i = 0; i < 8; i++) begin
         w = mk($urandom_range(0, 1), 3, $urandom_range(0, 15), $urandom_range(0, 3), $urandom);
         tries = 0;
         while (tries < 20) begin
            if (model_ready(w, 1'b0)) begin
               step(1'b1, w, 1'b0, tries[0] == 1'b0, 1'b0);
               break;
            end
            step(1'b1, w, 1'b0, tries[0] == 1'b0, 1'b0);
            tries++;
         end
         if (tries == 20) check("fwd_timeout", 1, 0);
      end
      idle(4, 1'b0, 1'b1);
      check("fwd_count", n_out - out0, 8);

      // out-of-range address, then clear
      step(1'b1, mk(0, 0, 7, 0, 'h1111), 1'b0, 1'b1, 1'b0);
      check("addr_err_set", addr_err, 1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("addr_err_clr", addr_err, 0);

      // valid low: no write
      step(1'b0, mk(1, 0, 1, 2, 'h5555), 1'b0, 1'b1, 1'b0);
      check("no_write", local_inst[31:16], 'h0055);
      check("no_push", start_cnt, 0);

`ifdef INST_PARSE_BCAST_EN
      step(1'b1, mk(1, 7, 0, 2, 'h1234), 1'b0, 1'b0, 1'b0);
      check("bc_reg0", local_inst[15:0], 'h1234);
      check("bc_push", start_cnt, 1);
      check("bc_fwd", inst_s_data, mk(1, 7, 0, 2, 'h1234));
      idle(2, 1'b1, 1'b1);
`endif

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         w = mk($urandom_range(0, 1), ids[$urandom_range(0, 3)], $urandom_range(0, 15),
                $urandom_range(0, 3), $urandom);
         step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      end

      // mid-operation reset flushes everything
      for (int i = 0; i < 6; i++) step(1'b1, mk(1, (i % 2) * 3, i, i, i), 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      model_reset();
      check("mid_rst_s_data", inst_s_data, 0);
      check_state();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         w = mk($urandom_range(0, 1), ids[$urandom_range(0, 3)], $urandom_range(0, 15),
                $urandom_range(0, 3), $urandom);
         step($urandom_range(0, 1) == 1, w, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 1'b0);
      end

      // final report
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
